// File: rtl/ddr2_bist_pkg.sv
// Shared types and helpers for the DDR2 pattern generator/checker.
package ddr2_bist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WAIT  = 3'd2,
        READ  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    localparam logic [15:0] ERR_SAT = 16'hFFFF;

    // The pass number in the upper half makes data left over from an earlier pass miscompare.
    function automatic logic [31:0] pat(input logic [15:0] p, input logic [15:0] i);
        return {p, i};
    endfunction

endpackage

// File: rtl/ddr2_bist_if.sv
// User-port bundle between the BIST and the DDR2 controller's write/read FIFOs.
// Request-only handshake, no back-pressure: wr_en qualifies wr_data in the same cycle;
// each rd_en cycle pops one word, which appears on rd_data RD_LAT cycles later.
interface ddr2_bist_if;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [31:0] rd_data;

    modport master (output wr_en, output wr_data, output rd_en, input rd_data);
    modport slave  (input wr_en, input wr_data, input rd_en, output rd_data);
endinterface

// File: rtl/ddr2_bist_cmp.sv
// Read-data checker: delays the expected word alongside rd_en, compares on arrival,
// and keeps the sticky error flag and saturating error count.
module ddr2_bist_cmp
    import ddr2_bist_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        rd_en,
    input  logic [31:0] exp_word,
    input  logic [31:0] rd_data,
    output logic        error_flag,
    output logic [15:0] err_cnt
);

    logic [RD_LAT-1:0]       vld_d;
    logic [RD_LAT-1:0][31:0] exp_d;
    logic                    hit;

    assign hit = vld_d[RD_LAT-1] && !flush && (rd_data != exp_d[RD_LAT-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_d      <= '0;
            exp_d      <= '0;
            error_flag <= 1'b0;
            err_cnt    <= '0;
        end else begin
            // An aborted run must not score words still in flight.
            vld_d[0] <= rd_en && !flush;
            exp_d[0] <= exp_word;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_d[k] <= vld_d[k-1] && !flush;
                exp_d[k] <= exp_d[k-1];
            end
            if (hit) begin
                error_flag <= 1'b1;
                if (err_cnt != ERR_SAT) err_cnt <= err_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/ddr2_bist.sv
// DDR2 traffic generator: writes a pass-tagged pattern in gapped bursts, waits,
// reads it back through the checker, and repeats while the controller is ready.
module ddr2_bist
    import ddr2_bist_pkg::*;
#(
    parameter int NUM_WORDS   = 1024,
    parameter int BURST       = 64,
    parameter int GAP_CYCLES  = 32,
    parameter int WAIT_CYCLES = 4096,
    parameter int RD_LAT      = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ddr2_init_done,
    ddr2_bist_if.master        bus,
    output logic               error_flag,
    output logic [15:0]        err_cnt,
    output logic [15:0]        pass_cnt,
    output logic               busy,
    output state_t             state
);

    localparam logic [31:0] BURST_LAST = 32'(BURST - 1);
    localparam logic [31:0] GAP_LAST   = 32'(GAP_CYCLES - 1);
    localparam logic [31:0] WAIT_LAST  = 32'(WAIT_CYCLES - 1);
    localparam logic [31:0] DRAIN_LAST = 32'(RD_LAT);
    localparam logic [15:0] IDX_LAST   = 16'(NUM_WORDS - 1);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        in_gap_q, in_gap_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] pass_q, pass_d;
    logic        wr_en_q, wr_en_d, rd_en_q, rd_en_d, busy_q, beat;
    logic [31:0] wr_data_q, wr_data_d;
    logic        flush;

    assign flush = (state_q != IDLE) && !ddr2_init_done;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in_gap_d  = in_gap_q;
        idx_d     = idx_q;
        pass_d    = pass_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        beat      = 1'b0;
        if (flush) begin
            state_d  = IDLE;
            cnt_d    = '0;
            in_gap_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (ddr2_init_done) begin
                    state_d  = WRITE;
                    cnt_d    = '0;
                    in_gap_d = 1'b0;
                    idx_d    = '0;
                    beat     = 1'b1;
                end
                // idx_q is the word on the bus this cycle; the final gap is kept before leaving.
                WRITE, READ: begin
                    if (!in_gap_q) begin
                        if (cnt_q == BURST_LAST) begin
                            in_gap_d = 1'b1;
                            cnt_d    = '0;
                        end else begin
                            cnt_d = cnt_q + 32'd1;
                            idx_d = idx_q + 16'd1;
                            beat  = 1'b1;
                        end
                    end else if (cnt_q != GAP_LAST) begin
                        cnt_d = cnt_q + 32'd1;
                    end else if (idx_q == IDX_LAST) begin
                        state_d  = (state_q == WRITE) ? WAIT : DRAIN;
                        cnt_d    = '0;
                        in_gap_d = 1'b0;
                    end else begin
                        cnt_d    = '0;
                        in_gap_d = 1'b0;
                        idx_d    = idx_q + 16'd1;
                        beat     = 1'b1;
                    end
                end
                WAIT: if (cnt_q == WAIT_LAST) begin
                    state_d = READ;
                    cnt_d   = '0;
                    idx_d   = '0;
                    beat    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
                DRAIN: if (cnt_q == DRAIN_LAST) begin
                    state_d = WRITE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    pass_d  = pass_q + 16'd1;
                    beat    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
                default: state_d = IDLE;
            endcase
        end
        if (beat) begin
            if (state_d == WRITE) begin
                wr_en_d   = 1'b1;
                wr_data_d = pat(pass_d, idx_d);
            end else begin
                rd_en_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            in_gap_q  <= 1'b0;
            idx_q     <= '0;
            pass_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            in_gap_q  <= in_gap_d;
            idx_q     <= idx_d;
            pass_q    <= pass_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            rd_en_q   <= rd_en_d;
            busy_q    <= (state_d != IDLE);
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_data = wr_data_q;
    assign bus.rd_en   = rd_en_q;
    assign pass_cnt    = pass_q;
    assign busy        = busy_q;
    assign state       = state_q;

    ddr2_bist_cmp #(.RD_LAT(RD_LAT)) u_cmp (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .rd_en      (rd_en_q),
        .exp_word   (pat(pass_q, idx_q)),
        .rd_data    (bus.rd_data),
        .error_flag (error_flag),
        .err_cnt    (err_cnt)
    );

endmodule

// File: tb/tb_ddr2_bist.sv
// Bench for ddr2_bist: loopback memory model with corruption/stale knobs and a
// write-data scoreboard, driven by one directed sequence.
module tb_ddr2_bist;
    import ddr2_bist_pkg::*;

    localparam int NW       = 256;
    localparam int BU       = 64;
    localparam int GAP      = 4;
    localparam int WAITC    = 16;
    localparam int RL       = 1;
    localparam int PASS_CYC = 2*NW + 2*(NW/BU)*GAP + WAITC + RL + 1;

    // clock / reset
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_done = 1'b0;
    logic        error_flag, busy;
    logic [15:0] err_cnt, pass_cnt;
    state_t      state;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ddr2_bist_if bus();

    ddr2_bist #(
        .NUM_WORDS(NW), .BURST(BU), .GAP_CYCLES(GAP), .WAIT_CYCLES(WAITC), .RD_LAT(RL)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ddr2_init_done (init_done),
        .bus            (bus),
        .error_flag     (error_flag),
        .err_cnt        (err_cnt),
        .pass_cnt       (pass_cnt),
        .busy           (busy),
        .state          (state)
    );

    // loopback memory: address taken from the word index in the low half
    logic [31:0] mem [NW];
    int          rp = 0;
    bit          corrupt17 = 1'b0;
    bit          freeze = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd_data <= '0;
        end else begin
            if (bus.wr_en && !freeze) mem[int'(bus.wr_data[15:0]) % NW] <= bus.wr_data;
            if (bus.rd_en) begin
                bus.rd_data <= mem[rp] ^ ((corrupt17 && rp == 17) ? 32'h1 : 32'h0);
                rp <= (rp + 1) % NW;
            end
        end
    end

    // scoreboard
    logic [31:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          pass_cyc[8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_pass(input int p);
        for (int i = 0; i < NW; i++) exp_q.push_back(pat(16'(p), 16'(i)));
    endtask

    task automatic wait_pass(input int target);
        int n = 0;
        while (pass_cnt != 16'(target) && n < 3*PASS_CYC) begin
            @(negedge clk);
            n++;
        end
        check("pass_cnt_reached", 32'(pass_cnt), 32'(target));
        pass_cyc[target] = cyc;
    endtask

    // output monitor: write words against the queue, read-17 and flag-rise timestamps
    int   rd_idx = 0;
    int   rd17_cyc = -1;
    int   rise_cyc = -1;
    logic flag_prev = 1'b0;

    always @(negedge clk) begin
        logic [31:0] exp_w;
        if (rst_n && bus.wr_en) begin
            if (exp_q.size() == 0) begin
                check("wr_queue_nonempty", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_w = exp_q.pop_front();
                check("wr_data", bus.wr_data, exp_w);
            end
        end
        if (rst_n && bus.rd_en) begin
            if (rd_idx == 17) rd17_cyc = cyc;
            rd_idx = (rd_idx + 1) % NW;
        end
        if (error_flag && !flag_prev) rise_cyc = cyc;
        flag_prev = error_flag;
    end

    // directed sequence
    initial begin
        int n;
        rst_n = 1'b0;
        init_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_wr_data", bus.wr_data, 32'd0);
        check("rst_rd_en", 32'(bus.rd_en), 32'd0);
        check("rst_error_flag", 32'(error_flag), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_pass_cnt", 32'(pass_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(state), 32'(IDLE));

        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_hold_state", 32'(state), 32'(IDLE));
        check("idle_hold_wr_en", 32'(bus.wr_en), 32'd0);

        push_pass(0);
        init_done = 1'b1;
        @(negedge clk);
        check("start_state", 32'(state), 32'(WRITE));
        check("start_busy", 32'(busy), 32'd1);
        check("start_wr_en", 32'(bus.wr_en), 32'd1);
        check("start_wr_data", bus.wr_data, pat(16'd0, 16'd0));

        // drop init_done while word 100 is on the bus
        n = 0;
        while (!(bus.wr_en && bus.wr_data == pat(16'd0, 16'd100)) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach_w100", bus.wr_data, pat(16'd0, 16'd100));
        init_done = 1'b0;
        @(negedge clk);
        check("abort_wr_en", 32'(bus.wr_en), 32'd0);
        check("abort_state", 32'(state), 32'(IDLE));
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_pass_cnt", 32'(pass_cnt), 32'd0);
        repeat (3) @(negedge clk);
        check("abort_idle_wr_en", 32'(bus.wr_en), 32'd0);
        exp_q.delete();
        push_pass(0);
        init_done = 1'b1;
        @(negedge clk);
        check("restart_wr_en", 32'(bus.wr_en), 32'd1);
        check("restart_wr_data", bus.wr_data, pat(16'd0, 16'd0));

        // clean pass 0
        push_pass(1);
        wait_pass(1);
        check("clean_error_flag", 32'(error_flag), 32'd0);
        check("clean_err_cnt", 32'(err_cnt), 32'd0);

        // pass 1: word 17 corrupted
        corrupt17 = 1'b1;
        push_pass(2);
        wait_pass(2);
        corrupt17 = 1'b0;
        check("err_latency", 32'(rise_cyc - rd17_cyc), 32'd2);
        check("corrupt_error_flag", 32'(error_flag), 32'd1);
        check("corrupt_err_cnt", 32'(err_cnt), 32'd1);

        // pass 2 clean, and pass length
        push_pass(3);
        wait_pass(3);
        check("pass_length", 32'(pass_cyc[3] - pass_cyc[2]), 32'(PASS_CYC));
        check("after_clean_err_cnt", 32'(err_cnt), 32'd1);

        // pass 3 reads pass 2 data
        freeze = 1'b1;
        push_pass(4);
        wait_pass(4);
        freeze = 1'b0;
        check("stale_err_cnt", 32'(err_cnt), 32'd257);
        check("stale_error_flag", 32'(error_flag), 32'd1);

        // preload near saturation, then another stale pass
        force dut.u_cmp.err_cnt = 16'hFF80;
        #1;
        release dut.u_cmp.err_cnt;
        push_pass(5);
        wait_pass(5);
        check("preload_hold", 32'(err_cnt), 32'h0000FF80);
        freeze = 1'b1;
        push_pass(6);
        wait_pass(6);
        freeze = 1'b0;
        check("err_saturate", 32'(err_cnt), 32'h0000FFFF);

        // asynchronous reset in the middle of a read burst
        n = 0;
        while (state != READ && n < 2*PASS_CYC) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        check("mid_read_rd_en", 32'(bus.rd_en), 32'd1);
        check("mid_read_flag", 32'(error_flag), 32'd1);
        #2;
        rst_n = 1'b0;
        init_done = 1'b0;
        #1;
        check("arst_rd_en", 32'(bus.rd_en), 32'd0);
        check("arst_wr_en", 32'(bus.wr_en), 32'd0);
        check("arst_wr_data", bus.wr_data, 32'd0);
        check("arst_error_flag", 32'(error_flag), 32'd0);
        check("arst_err_cnt", 32'(err_cnt), 32'd0);
        check("arst_pass_cnt", 32'(pass_cnt), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_state", 32'(state), 32'(IDLE));
        check("wr_queue_drained", 32'(exp_q.size()), 32'd0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
